pipe_stage_reg: RTL and testbench

- Parametrised pipeline-boundary register for inter-stage links (ID/EX, EX/MEM, and similar).
- Replaces ad-hoc stall/shadow-register logic with a valid/ready handshake and an in-order skid buffer of configurable depth.
- Adds a synchronous flush (branch/jump squash) and a configurable bubble payload driven whenever the output is invalid.
- Payload is an opaque DATA_W vector; each stage packs its own fields.

---
 rtl/pipe_pkg.sv | 62 ++++++
 rtl/pipe_skid_fifo.sv | 67 ++++++
 rtl/pipe_stage_reg.sv | 112 +++++++++++
 tb/tb_pipe_stage_reg.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline-boundary registers.
// Holds the per-stage payload field layouts, the NOP bubble constants
// driven by invalid stages, and a constant-foldable clog2 helper.
package pipe_pkg;

  // Ceiling log2 usable in parameter and port-width expressions.
  // Returns 0 for v <= 1.
  function automatic int unsigned pipe_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // ALU operation encoding carried in the ID/EX payload; all-zero is a NOP
  // so a zero bubble decodes as "do nothing" in EX.
  typedef enum logic [5:0] {
    ALU_NOP = 6'd0,
    ALU_ADD = 6'd1,
    ALU_SUB = 6'd2,
    ALU_AND = 6'd3,
    ALU_OR  = 6'd4,
    ALU_XOR = 6'd5,
    ALU_SLL = 6'd6,
    ALU_SRL = 6'd7
  } alu_op_e;

  // ID/EX payload layout
  localparam int ID_EX_OP1_LSB    = 0;
  localparam int ID_EX_OP1_W      = 32;
  localparam int ID_EX_OP2_LSB    = 32;
  localparam int ID_EX_OP2_W      = 32;
  localparam int ID_EX_IMM_LSB    = 64;
  localparam int ID_EX_IMM_W      = 32;
  localparam int ID_EX_RD_LSB     = 96;
  localparam int ID_EX_RD_W       = 5;
  localparam int ID_EX_ALU_OP_LSB = 101;
  localparam int ID_EX_ALU_OP_W   = 6;
  localparam int ID_EX_WB_EN_BIT  = 107;
  localparam int ID_EX_MEM_RE_BIT = 108;
  localparam int ID_EX_MEM_WE_BIT = 109;
  localparam int ID_EX_W          = 110;

  // EX/MEM payload layout
  localparam int EX_MEM_RESULT_LSB = 0;
  localparam int EX_MEM_RESULT_W   = 32;
  localparam int EX_MEM_STORE_LSB  = 32;
  localparam int EX_MEM_STORE_W    = 32;
  localparam int EX_MEM_RD_LSB     = 64;
  localparam int EX_MEM_RD_W       = 5;
  localparam int EX_MEM_WB_EN_BIT  = 69;
  localparam int EX_MEM_MEM_RE_BIT = 70;
  localparam int EX_MEM_MEM_WE_BIT = 71;
  localparam int EX_MEM_W          = 72;

  // Bubbles: ALU_NOP, no writeback, no memory access.
  localparam logic [ID_EX_W-1:0]  ID_EX_NOP  = '0;
  localparam logic [EX_MEM_W-1:0] EX_MEM_NOP = '0;

endpackage

// File: rtl/pipe_skid_fifo.sv
// pipe_skid_fifo: DEPTH-entry circular buffer used as the skid storage in
// front of a pipeline output register. Pointers wrap by explicit compare so
// non-power-of-two depths work. clear is synchronous and beats push/pop.
module pipe_skid_fifo
  import pipe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  localparam int PTR_W = (DEPTH > 1) ? int'(pipe_clog2(DEPTH)) : 1,
  localparam int CNT_W = int'(pipe_clog2(DEPTH + 1))
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  // A full buffer never takes a write, so held entries cannot be overwritten.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and count bookkeeping; simultaneous push/pop keeps count steady.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline-boundary register with an in-order
// skid buffer ahead of the output register, synchronous flush and a bubble
// value driven whenever the output is invalid.
// Optional build macro PIPE_STAGE_STALL_CNT_EN adds the stall_cycles
// counter and skid_hwm high-water mark outputs.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 128,
  parameter int                SKID_DEPTH = 2,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_W-1:0]                 in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_W-1:0]                 out_data,
  input  logic                              flush,
  output logic [$clog2(SKID_DEPTH+2)-1:0]   occupancy
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [31:0]                       stall_cycles,
  output logic [$clog2(SKID_DEPTH+1)-1:0]   skid_hwm
`endif
);

  localparam int CNT_W = int'(pipe_clog2(SKID_DEPTH + 1));
  localparam int OCC_W = $clog2(SKID_DEPTH + 2);

  logic              load_en;
  logic              accept;
  logic              sk_push;
  logic              sk_pop;
  logic              sk_full;
  logic              sk_empty;
  logic [CNT_W-1:0]  sk_count;
  logic [DATA_W-1:0] sk_head;

  // in_ready depends only on the registered skid count, never on out_ready.
  assign in_ready = !sk_full;
  assign accept   = in_valid && in_ready;
  assign load_en  = !out_valid || out_ready;

  // The skid head always goes first; a new beat bypasses the skid only when
  // nothing older is waiting and the output register is free this cycle.
  assign sk_pop  = !flush && load_en && !sk_empty;
  assign sk_push = !flush && accept && !(sk_empty && load_en);

  pipe_skid_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (SKID_DEPTH)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (sk_push),
    .pop   (sk_pop),
    .clear (flush),
    .din   (in_data),
    .dout  (sk_head),
    .count (sk_count),
    .full  (sk_full),
    .empty (sk_empty)
  );

  // Output register: flush squashes, otherwise reload from skid, input or bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= BUBBLE_VAL;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_data  <= BUBBLE_VAL;
    end else if (load_en) begin
      if (!sk_empty) begin
        out_valid <= 1'b1;
        out_data  <= sk_head;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
        out_data  <= BUBBLE_VAL;
      end
    end
  end

  assign occupancy = OCC_W'(out_valid) + OCC_W'(sk_count);

`ifdef PIPE_STAGE_STALL_CNT_EN
  // Saturating count of cycles where valid output is held back downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

  // Deepest skid fill seen since reset; flush does not clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_hwm <= '0;
    end else if (sk_count > skid_hwm) begin
      skid_hwm <= sk_count;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: two instances (skid depth 2 and 3) checked cycle by
// cycle against a queue model: the queue holds every beat currently inside
// the stage, its front is what the output must show.
module tb_pipe_stage_reg;

  localparam logic [15:0] A_BUB = 16'hB0BB;
  localparam logic [11:0] B_BUB = 12'hF0F;

  logic clk = 1'b0;
  logic rst;

  logic        a_iv, a_ir, a_ov, a_or, a_fl;
  logic [15:0] a_id, a_od;
  logic [1:0]  a_occ;
  logic        b_iv, b_ir, b_ov, b_or, b_fl;
  logic [11:0] b_id, b_od;
  logic [2:0]  b_occ;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [31:0] a_stall, b_stall;
  logic [1:0]  a_hwm, b_hwm;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(16), .SKID_DEPTH(2), .BUBBLE_VAL(A_BUB)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .flush(a_fl),
    .occupancy(a_occ)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cycles(a_stall), .skid_hwm(a_hwm)
`endif
  );

  pipe_stage_reg #(.DATA_W(12), .SKID_DEPTH(3), .BUBBLE_VAL(B_BUB)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .flush(b_fl),
    .occupancy(b_occ)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cycles(b_stall), .skid_hwm(b_hwm)
`endif
  );

  // ---------------- reference model ----------------
  logic [15:0] qa[$];
  logic [11:0] qb[$];
  logic [31:0] ma_stall;
  int          ma_hwm;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa.delete();
      ma_stall <= 32'd0;
      ma_hwm   <= 0;
    end else begin : mdl_a
      int sz;
      sz = qa.size();
      if (sz > 0 && !a_or && ma_stall != 32'hFFFF_FFFF) ma_stall <= ma_stall + 32'd1;
      if (a_fl) qa.delete();
      else begin
        if (sz > 0 && a_or) void'(qa.pop_front());
        if (a_iv && sz <= 2) qa.push_back(a_id);
      end
      if (qa.size() > 1 && qa.size() - 1 > ma_hwm) ma_hwm <= qa.size() - 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qb.delete();
    end else begin : mdl_b
      int sz;
      sz = qb.size();
      if (b_fl) qb.delete();
      else begin
        if (sz > 0 && b_or) void'(qb.pop_front());
        if (b_iv && sz <= 3) qb.push_back(b_id);
      end
    end
  end

  // Expected {out_valid, out_data, in_ready, occupancy} from the queues.
  function automatic logic [19:0] a_exp();
    logic ov;
    ov = qa.size() > 0;
    return {ov, ov ? qa[0] : A_BUB, qa.size() <= 2, 2'(qa.size())};
  endfunction

  function automatic logic [16:0] b_exp();
    logic ov;
    ov = qb.size() > 0;
    return {ov, ov ? qb[0] : B_BUB, qb.size() <= 3, 3'(qb.size())};
  endfunction

  logic [19:0] a_got;
  logic [16:0] b_got;
  assign a_got = {a_ov, a_od, a_ir, a_occ};
  assign b_got = {b_ov, b_od, b_ir, b_occ};

  // ---------------- tests ----------------
  task automatic test_reset;
    vectors++;
    if (a_got !== a_exp()) begin
      errors++; $display("FAIL reset_a_model got=%h exp=%h", a_got, a_exp());
    end
    vectors++;
    if (a_got !== {1'b0, A_BUB, 1'b1, 2'd0}) begin
      errors++; $display("FAIL reset_a got=%h exp=%h", a_got, {1'b0, A_BUB, 1'b1, 2'd0});
    end
    vectors++;
    if (b_got !== {1'b0, B_BUB, 1'b1, 3'd0}) begin
      errors++; $display("FAIL reset_b got=%h exp=%h", b_got, {1'b0, B_BUB, 1'b1, 3'd0});
    end
  endtask

  task automatic test_streaming;
    a_or = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_iv = 1'b1; a_id = 16'(i);
      @(negedge clk);
      vectors++;
      if (a_got !== a_exp()) begin
        errors++; $display("FAIL stream_model i=%0d got=%h exp=%h", i, a_got, a_exp());
      end
      vectors++;
      if (a_ov !== 1'b1 || a_od !== 16'(i)) begin
        errors++; $display("FAIL stream_latency i=%0d got ov=%b data=%h exp ov=1 data=%h", i, a_ov, a_od, 16'(i));
      end
      vectors++;
      if (a_occ > 2'd1) begin
        errors++; $display("FAIL stream_occ i=%0d got=%0d exp<=1", i, a_occ);
      end
    end
    a_iv = 1'b0;
    @(negedge clk);
    vectors++;
    if (a_got !== a_exp()) begin
      errors++; $display("FAIL stream_drain got=%h exp=%h", a_got, a_exp());
    end
  endtask

  task automatic test_stall_fill;
    logic [15:0] seen[$];
    a_or = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_iv = 1'b1; a_id = 16'hA + 16'(i);
      @(negedge clk);
      vectors++;
      if (a_got !== a_exp()) begin
        errors++; $display("FAIL fill_model i=%0d got=%h exp=%h", i, a_got, a_exp());
      end
    end
    vectors++;
    if (a_ir !== 1'b0) begin
      errors++; $display("FAIL fill_in_ready got=%b exp=0", a_ir);
    end
    a_iv = 1'b0; a_or = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (a_ov === 1'b1 && a_or) seen.push_back(a_od);
      @(negedge clk);
      vectors++;
      if (a_got !== a_exp()) begin
        errors++; $display("FAIL release_model k=%0d got=%h exp=%h", k, a_got, a_exp());
      end
      if (k == 0) begin
        vectors++;
        if (a_ir !== 1'b1) begin
          errors++; $display("FAIL release_in_ready got=%b exp=1", a_ir);
        end
      end
    end
    vectors++;
    if (seen.size() != 3 || seen[0] !== 16'hA || seen[1] !== 16'hB || seen[2] !== 16'hC) begin
      errors++; $display("FAIL release_order got n=%0d exp n=3 (A,B,C)", seen.size());
    end
  endtask

  task automatic test_flush;
    a_or = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_iv = 1'b1; a_id = 16'h11 + 16'(i);
      @(negedge clk);
      vectors++;
      if (a_got !== a_exp()) begin
        errors++; $display("FAIL flush_fill i=%0d got=%h exp=%h", i, a_got, a_exp());
      end
    end
    a_id = 16'hD; a_fl = 1'b1;
    @(negedge clk);
    a_fl = 1'b0; a_iv = 1'b0; a_or = 1'b1;
    vectors++;
    if (a_got !== {1'b0, A_BUB, 1'b1, 2'd0}) begin
      errors++; $display("FAIL flush_full got=%h exp=%h", a_got, {1'b0, A_BUB, 1'b1, 2'd0});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (a_got !== a_exp() || (a_ov === 1'b1 && a_od === 16'hD)) begin
        errors++; $display("FAIL flush_after k=%0d got=%h exp=%h", k, a_got, a_exp());
      end
    end
    // one held beat delivered in the flush cycle, accepted input discarded
    a_or = 1'b0; a_iv = 1'b1; a_id = 16'h21;
    @(negedge clk);
    a_id = 16'hE; a_fl = 1'b1; a_or = 1'b1;
    @(negedge clk);
    a_fl = 1'b0; a_iv = 1'b0;
    vectors++;
    if (a_got !== a_exp() || a_ov !== 1'b0) begin
      errors++; $display("FAIL flush_xfer got=%h exp=%h", a_got, a_exp());
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (a_got !== a_exp() || (a_ov === 1'b1 && a_od === 16'hE)) begin
        errors++; $display("FAIL flush_discard k=%0d got=%h exp=%h", k, a_got, a_exp());
      end
    end
  endtask

  task automatic test_reset_midstream;
    a_or = 1'b0; a_iv = 1'b1; a_id = 16'h41;
    @(negedge clk);
    a_id = 16'h42;
    @(negedge clk);
    a_iv = 1'b0;
    vectors++;
    if (a_got !== a_exp() || a_occ !== 2'd2) begin
      errors++; $display("FAIL pre_reset got=%h exp=%h", a_got, a_exp());
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (a_got !== {1'b0, A_BUB, 1'b1, 2'd0}) begin
      errors++; $display("FAIL async_reset got=%h exp=%h", a_got, {1'b0, A_BUB, 1'b1, 2'd0});
    end
    @(negedge clk);
    rst = 1'b0; a_or = 1'b1;
    @(negedge clk);
    vectors++;
    if (a_got !== a_exp()) begin
      errors++; $display("FAIL post_reset got=%h exp=%h", a_got, a_exp());
    end
  endtask

  task automatic test_wrap;
    logic [14:0] vpat, rpat;
    for (int p = 0; p < 20; p++) begin
      vpat = 15'($urandom);
      rpat = 15'($urandom);
      for (int c = 0; c < 15; c++) begin
        b_iv = vpat[c];
        b_or = rpat[c];
        b_id = 12'($urandom);
        b_fl = ($urandom_range(0, 49) == 0);
        @(negedge clk);
        vectors++;
        if (b_got !== b_exp()) begin
          errors++; $display("FAIL wrap p=%0d c=%0d got=%h exp=%h", p, c, b_got, b_exp());
        end
        vectors++;
        if (b_ov === 1'b0 && b_od !== B_BUB) begin
          errors++; $display("FAIL wrap_bubble p=%0d c=%0d got=%h exp=%h", p, c, b_od, B_BUB);
        end
      end
    end
    b_iv = 1'b0; b_or = 1'b1; b_fl = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      vectors++;
      if (b_got !== b_exp()) begin
        errors++; $display("FAIL wrap_drain k=%0d got=%h exp=%h", k, b_got, b_exp());
      end
    end
  endtask

`ifdef PIPE_STAGE_STALL_CNT_EN
  task automatic test_stall_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a_or = 1'b0; a_iv = 1'b1; a_id = 16'h51;
    @(negedge clk);
    a_id = 16'h52;
    @(negedge clk);
    a_id = 16'h53;
    @(negedge clk);
    a_iv = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (a_stall !== 32'd5 || a_stall !== ma_stall) begin
      errors++; $display("FAIL stall_cnt got=%0d exp=5 model=%0d", a_stall, ma_stall);
    end
    vectors++;
    if (a_hwm !== 2'd2 || int'(a_hwm) != ma_hwm) begin
      errors++; $display("FAIL skid_hwm got=%0d exp=2 model=%0d", a_hwm, ma_hwm);
    end
    a_fl = 1'b1; a_or = 1'b1;
    @(negedge clk);
    a_fl = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (a_stall !== 32'd5 || a_stall !== ma_stall) begin
      errors++; $display("FAIL stall_after_flush got=%0d exp=5 model=%0d", a_stall, ma_stall);
    end
    vectors++;
    if (a_hwm !== 2'd2) begin
      errors++; $display("FAIL hwm_after_flush got=%0d exp=2", a_hwm);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_iv = 1'b0; a_id = '0; a_or = 1'b1; a_fl = 1'b0;
    b_iv = 1'b0; b_id = '0; b_or = 1'b1; b_fl = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_stall_fill();
    test_flush();
    test_reset_midstream();
    test_wrap();
`ifdef PIPE_STAGE_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
